s2p_input_capture: RTL and testbench
====================================

Name: s2p_input_capture

Overview:
- Serial-to-parallel input stage of the stereo audio path; it sits directly upstream of the processing core.
- Deserializes the left and right serial input bit streams, MSB first. Each word is framed by a one-cycle Frame pulse on Sclk.
- Delivers each completed stereo sample pair with a one-cycle InReady strobe.
- Flags framing errors and long runs of all-zero input. The core uses the zero-run flag for sleep-mode entry.

Parameters:
- DATA_W, 16, bits per channel sample.
- ZERO_RUN, 800, consecutive all-zero sample pairs (both channels) needed to assert ZeroDetect.
- CNT_W, 10, zero-run counter width; must hold ZERO_RUN.

Ports:
- Sclk  input  1  serial bit clock; all state updates on posedge.
- Reset_n  input  1  asynchronous, active-low reset.
- Frame  input  1  word-start strobe, high for one Sclk cycle, coincident with the MSB.
- InputL  input  1  left channel serial data.
- InputR  input  1  right channel serial data.
- S2P_enable  input  1  capture enable; gates word start.
- DataL  output  DATA_W  last completed left sample.
- DataR  output  DATA_W  last completed right sample.
- InReady  output  1  one-cycle strobe: DataL/DataR updated.
- FrameErr  output  1  one-cycle strobe: partial word discarded due to early Frame.
- ZeroDetect  output  1  level: ZERO_RUN consecutive zero pairs received.
- BitCnt  output  $clog2(DATA_W+1)  bits captured in current word; 0 in IDLE.

Behaviour:
- Reset (Reset_n low, async, takes effect without a clock):
  - DataL, DataR, InReady, FrameErr, ZeroDetect, BitCnt and the zero counter all go to 0.
  - State goes to IDLE and the shift registers clear.
- State machine: IDLE, SHIFT. All decisions use values sampled at posedge Sclk.
- IDLE:
  - Frame=1 and S2P_enable=1: capture InputL/InputR into bit DATA_W-1, set BitCnt=1, go to SHIFT.
  - Frame with S2P_enable=0 is ignored.
- SHIFT, normal capture: each edge captures the next lower bit and increments BitCnt.
- SHIFT, word completion: on the edge capturing the LSB (BitCnt was DATA_W-1):
  - DataL/DataR load the full words.
  - InReady=1 for exactly the following cycle.
  - BitCnt=0, state returns to IDLE.
  - Latency: InReady is high in the cycle after the LSB edge, i.e. DATA_W edges after the Frame edge.
- Back-to-back words: Frame in the first IDLE cycle after completion (period of exactly DATA_W cycles) is a legal new word. No gap cycle is required.
- Early Frame: Frame=1 while in SHIFT (including on the LSB edge) with S2P_enable=1:
  - Partial word is discarded; DataL/DataR are unchanged and no InReady is issued.
  - FrameErr=1 for the following cycle.
  - The same edge is treated as a new word start: MSB captured, BitCnt=1, stay in SHIFT.
- Enable drop: S2P_enable=0 while in SHIFT aborts the word silently.
  - Return to IDLE, BitCnt=0.
  - No InReady, no FrameErr.
  - This rule takes priority over Early Frame.
- DataL/DataR hold their value until the next completed word.
- InReady and FrameErr are never high in the same cycle.
- Zero-run detection, updated only on completed words, on the same edge that loads DataL/DataR:
  - Both words zero: counter increments, saturating at ZERO_RUN.
  - Either word nonzero: counter clears to 0.
  - ZeroDetect is registered and equals (counter == ZERO_RUN) after the update. It therefore changes in the same cycle InReady is high.
  - Discarded or aborted words do not affect the counter.
- Reset mid-word: partial word is lost. The first Frame after Reset_n deasserts starts capture normally.

Test Plan:
- Reset, then Frame with S2P_enable=1, InputL=0xA5C3 and InputR=0x1234 MSB-first -> InReady high exactly one cycle, 16 edges after the Frame edge; DataL=0xA5C3, DataR=0x1234; BitCnt counts 1..15 then returns to 0.
- Three back-to-back frames, period 16 cycles, with L/R words 0x0001/0x8000, 0xFFFF/0x0000, 0x7FFE/0x5555 -> three InReady pulses 16 cycles apart with matching DataL/DataR; FrameErr stays 0.
- Frame reasserted at BitCnt=8, then a full word 0xBEEF/0xCAFE -> FrameErr pulses once and no InReady for the partial word; DataL/DataR keep their prior value, then become 0xBEEF/0xCAFE with a single InReady.
- S2P_enable=0 with a Frame pulse -> no activity, BitCnt stays 0. Enable high, Frame, then enable dropped at BitCnt=5 -> no InReady, no FrameErr, BitCnt goes to 0.
- With ZERO_RUN=4: four 0x0000/0x0000 words -> ZeroDetect rises with the 4th InReady and stays high through a 5th zero word. Then word 0x0000/0x0001 -> ZeroDetect falls with that InReady.
- Reset_n pulsed low at BitCnt=10 between clock edges -> all outputs 0 immediately. Next Frame with 0x1357/0x2468 -> normal capture and InReady.

Source files
------------

// File: rtl/s2p_input_capture_if.sv
// Bus between the serial front end and the s2p_input_capture stage:
// serial inputs in, deserialized stereo samples and status out.
interface s2p_input_capture_if #(
  parameter int DATA_W = 16
);
  localparam int BC_W = $clog2(DATA_W + 1);

  logic              Frame;
  logic              InputL;
  logic              InputR;
  logic              S2P_enable;
  logic [DATA_W-1:0] DataL;
  logic [DATA_W-1:0] DataR;
  logic              InReady;
  logic              FrameErr;
  logic              ZeroDetect;
  logic [BC_W-1:0]   BitCnt;

  modport master (
    output Frame, InputL, InputR, S2P_enable,
    input  DataL, DataR, InReady, FrameErr, ZeroDetect, BitCnt
  );

  modport slave (
    input  Frame, InputL, InputR, S2P_enable,
    output DataL, DataR, InReady, FrameErr, ZeroDetect, BitCnt
  );
endinterface

// File: rtl/s2p_input_capture.sv
// Stereo serial-to-parallel input stage: MSB-first capture framed by Frame,
// with framing-error strobe and zero-run detection for sleep entry.
module s2p_input_capture #(
  parameter int DATA_W   = 16,
  parameter int ZERO_RUN = 800,
  parameter int CNT_W    = 10
) (
  input  logic                Sclk,
  input  logic                Reset_n,
  s2p_input_capture_if.slave  bus
);
  localparam int BC_W = $clog2(DATA_W + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]        r_state;
  logic [DATA_W-1:0] r_sh_l;
  logic [DATA_W-1:0] r_sh_r;
  logic [DATA_W-1:0] r_data_l;
  logic [DATA_W-1:0] r_data_r;
  logic              r_in_ready;
  logic              r_frame_err;
  logic              r_zero_det;
  logic [BC_W-1:0]   r_bit_cnt;
  logic [CNT_W-1:0]  r_zero_cnt;

  logic              w_start;
  logic              w_last;
  logic [DATA_W-1:0] w_word_l;
  logic [DATA_W-1:0] w_word_r;
  logic [CNT_W-1:0]  w_zero_cnt_nxt;

  always_comb begin
    w_start  = bus.Frame & bus.S2P_enable;
    w_last   = (r_bit_cnt == BC_W'(DATA_W - 1));
    // Words are shifted in at the LSB end; after DATA_W bits the first bit sits at the MSB.
    w_word_l = {r_sh_l[DATA_W-2:0], bus.InputL};
    w_word_r = {r_sh_r[DATA_W-2:0], bus.InputR};
    w_zero_cnt_nxt = '0;
    if ((w_word_l == '0) && (w_word_r == '0)) begin
      w_zero_cnt_nxt = (r_zero_cnt == CNT_W'(ZERO_RUN)) ? r_zero_cnt
                                                         : r_zero_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= S_IDLE;
      r_sh_l      <= '0;
      r_sh_r      <= '0;
      r_data_l    <= '0;
      r_data_r    <= '0;
      r_in_ready  <= 1'b0;
      r_frame_err <= 1'b0;
      r_zero_det  <= 1'b0;
      r_bit_cnt   <= '0;
      r_zero_cnt  <= '0;
    end else begin
      r_in_ready  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_sh_l    <= {{(DATA_W-1){1'b0}}, bus.InputL};
            r_sh_r    <= {{(DATA_W-1){1'b0}}, bus.InputR};
            r_bit_cnt <= BC_W'(1);
            r_state   <= S_SHIFT;
          end
        end
        default: begin
          // Enable drop outranks an early Frame on the same edge.
          if (!bus.S2P_enable) begin
            r_bit_cnt <= '0;
            r_state   <= S_IDLE;
          end else if (bus.Frame) begin
            r_frame_err <= 1'b1;
            r_sh_l      <= {{(DATA_W-1){1'b0}}, bus.InputL};
            r_sh_r      <= {{(DATA_W-1){1'b0}}, bus.InputR};
            r_bit_cnt   <= BC_W'(1);
          end else if (w_last) begin
            r_data_l   <= w_word_l;
            r_data_r   <= w_word_r;
            r_in_ready <= 1'b1;
            r_zero_cnt <= w_zero_cnt_nxt;
            r_zero_det <= (w_zero_cnt_nxt == CNT_W'(ZERO_RUN));
            r_bit_cnt  <= '0;
            r_state    <= S_IDLE;
          end else begin
            r_sh_l    <= w_word_l;
            r_sh_r    <= w_word_r;
            r_bit_cnt <= r_bit_cnt + BC_W'(1);
          end
        end
      endcase
    end
  end

  assign bus.DataL      = r_data_l;
  assign bus.DataR      = r_data_r;
  assign bus.InReady    = r_in_ready;
  assign bus.FrameErr   = r_frame_err;
  assign bus.ZeroDetect = r_zero_det;
  assign bus.BitCnt     = r_bit_cnt;
endmodule

// File: tb/tb_s2p_input_capture.sv
// Bench for s2p_input_capture: word table, hand-written corner sequences and
// random serial traffic, all checked against a word-level reference model.
module tb_s2p_input_capture;
  localparam int DATA_W   = 16;
  localparam int ZERO_RUN = 4;
  localparam int CNT_W    = 3;

  logic Sclk;
  logic Reset_n;

  s2p_input_capture_if #(.DATA_W(DATA_W)) bus ();

  s2p_input_capture #(
    .DATA_W  (DATA_W),
    .ZERO_RUN(ZERO_RUN),
    .CNT_W   (CNT_W)
  ) dut (
    .Sclk   (Sclk),
    .Reset_n(Reset_n),
    .bus    (bus.slave)
  );

  initial Sclk = 1'b0;
  always #5 Sclk = ~Sclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a word is "open" after an enabled Frame and accumulates bits
  // arithmetically until DATA_W bits have arrived.
  bit m_open;
  int m_n;
  int m_acc_l, m_acc_r;
  int m_data_l, m_data_r;
  bit m_ready, m_err, m_zd;
  int m_run;

  task automatic model_reset();
    m_open = 0; m_n = 0; m_acc_l = 0; m_acc_r = 0;
    m_data_l = 0; m_data_r = 0; m_ready = 0; m_err = 0; m_zd = 0; m_run = 0;
  endtask

  task automatic model_edge(input bit f, input bit en, input bit l, input bit r);
    m_ready = 0;
    m_err   = 0;
    if (m_open && !en) begin
      m_open = 0;
      m_n    = 0;
    end else if (f && en) begin
      if (m_open) m_err = 1;
      m_open = 1; m_acc_l = l; m_acc_r = r; m_n = 1;
    end else if (m_open) begin
      m_acc_l = m_acc_l * 2 + l;
      m_acc_r = m_acc_r * 2 + r;
      m_n++;
      if (m_n == DATA_W) begin
        m_data_l = m_acc_l; m_data_r = m_acc_r; m_ready = 1;
        m_open = 0; m_n = 0;
        if (m_acc_l == 0 && m_acc_r == 0) m_run = (m_run < ZERO_RUN) ? m_run + 1 : ZERO_RUN;
        else m_run = 0;
        m_zd = (m_run == ZERO_RUN);
      end
    end
  endtask

  task automatic ck(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    ck("DataL",      int'(bus.DataL),      m_data_l);
    ck("DataR",      int'(bus.DataR),      m_data_r);
    ck("InReady",    int'(bus.InReady),    int'(m_ready));
    ck("FrameErr",   int'(bus.FrameErr),   int'(m_err));
    ck("ZeroDetect", int'(bus.ZeroDetect), int'(m_zd));
    ck("BitCnt",     int'(bus.BitCnt),     m_n);
  endtask

  task automatic step(input bit f, input bit en, input bit l, input bit r);
    bus.Frame = f; bus.S2P_enable = en; bus.InputL = l; bus.InputR = r;
    @(posedge Sclk);
    model_edge(f, en, l, r);
    #1;
    check_model();
  endtask

  task automatic send_bits(input logic [15:0] wl, input logic [15:0] wr,
                           input bit en, input int nbits);
    for (int i = 0; i < nbits; i++)
      step(i == 0, en, wl[15-i], wr[15-i]);
  endtask

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    bit          en;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
    bit          exp_rdy;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{16'hA5C3, 16'h1234, 1'b1, 16'hA5C3, 16'h1234, 1'b1};
    vecs[1] = '{16'h0001, 16'h8000, 1'b1, 16'h0001, 16'h8000, 1'b1};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFF, 16'h0000, 1'b1};
    vecs[3] = '{16'h7FFE, 16'h5555, 1'b1, 16'h7FFE, 16'h5555, 1'b1};
    vecs[4] = '{16'hDEAD, 16'hBEEF, 1'b0, 16'h7FFE, 16'h5555, 1'b0};
    vecs[5] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0F0F, 16'hF0F0, 1'b1};

    model_reset();
    bus.Frame = 0; bus.S2P_enable = 0; bus.InputL = 0; bus.InputR = 0;
    Reset_n = 0;
    repeat (2) @(posedge Sclk);
    #1;
    check_model();
    ck("reset_DataL", int'(bus.DataL), 0);
    @(negedge Sclk);
    Reset_n = 1;

    // Word table; consecutive entries run back-to-back with a 16-cycle period.
    foreach (vecs[k]) begin
      send_bits(vecs[k].l, vecs[k].r, vecs[k].en, DATA_W);
      ck("tbl_DataL",   int'(bus.DataL),   int'(vecs[k].exp_l));
      ck("tbl_DataR",   int'(bus.DataR),   int'(vecs[k].exp_r));
      ck("tbl_InReady", int'(bus.InReady), int'(vecs[k].exp_rdy));
    end
    step(0, 1, 0, 0);
    ck("ready_one_cycle", int'(bus.InReady), 0);

    // Early Frame at BitCnt=8, then a complete word.
    send_bits(16'h1111, 16'h2222, 1, 8);
    ck("pre_early_cnt", int'(bus.BitCnt), 8);
    step(1, 1, 1'b1, 1'b1);
    ck("early_err",   int'(bus.FrameErr), 1);
    ck("early_nordy", int'(bus.InReady),  0);
    ck("early_cnt",   int'(bus.BitCnt),   1);
    ck("early_keepL", int'(bus.DataL),    16'h0F0F);
    for (int i = 1; i < DATA_W; i++) step(0, 1, 16'hBEEF >> (15 - i), 16'hCAFE >> (15 - i));
    ck("early_DataL", int'(bus.DataL),    16'hBEEF);
    ck("early_DataR", int'(bus.DataR),    16'hCAFE);
    ck("early_rdy",   int'(bus.InReady),  1);
    ck("early_noerr", int'(bus.FrameErr), 0);

    // Frame while disabled, then enable drop at BitCnt=5.
    step(0, 1, 0, 0);
    step(1, 0, 1, 1);
    ck("dis_cnt", int'(bus.BitCnt), 0);
    send_bits(16'hFFFF, 16'hFFFF, 1, 5);
    ck("drop_pre_cnt", int'(bus.BitCnt), 5);
    step(1, 0, 1, 1);
    ck("drop_cnt", int'(bus.BitCnt),   0);
    ck("drop_rdy", int'(bus.InReady),  0);
    ck("drop_err", int'(bus.FrameErr), 0);

    // Zero run.
    for (int k = 1; k <= 5; k++) begin
      send_bits(16'h0000, 16'h0000, 1, DATA_W);
      ck("zero_rdy", int'(bus.InReady), 1);
      ck("zero_zd",  int'(bus.ZeroDetect), (k >= ZERO_RUN) ? 1 : 0);
    end
    send_bits(16'h0000, 16'h0001, 1, DATA_W);
    ck("zero_fall_rdy", int'(bus.InReady),    1);
    ck("zero_fall_zd",  int'(bus.ZeroDetect), 0);

    // Asynchronous reset mid-word at BitCnt=10.
    send_bits(16'hAAAA, 16'h5555, 1, 10);
    ck("rst_pre_cnt", int'(bus.BitCnt), 10);
    #2;
    Reset_n = 0;
    #1;
    model_reset();
    check_model();
    @(negedge Sclk);
    Reset_n = 1;
    send_bits(16'h1357, 16'h2468, 1, DATA_W);
    ck("post_rst_DataL", int'(bus.DataL),   16'h1357);
    ck("post_rst_DataR", int'(bus.DataR),   16'h2468);
    ck("post_rst_rdy",   int'(bus.InReady), 1);

    // Random traffic: mostly periodic frames, occasional early frames and enable drops.
    begin
      int  since;
      bit  zmode;
      bit  f;
      since = 16;
      zmode = 0;
      for (int c = 0; c < 3000; c++) begin
        if ((c % 400) == 0) zmode = ~zmode;
        f = (since >= 16) || ($urandom_range(0, 39) == 0);
        if (f) since = 0;
        since++;
        step(f, $urandom_range(0, 59) != 0,
             zmode ? ($urandom_range(0, 99) == 0) : 1'($urandom_range(0, 1)),
             zmode ? 1'b0 : 1'($urandom_range(0, 1)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
